// File: rtl/dca_matrix_row_buffer.sv
// dca_matrix_row_buffer
// Captures up to MATRIX_NUM_ROW tensor rows from the LSU load-row stream and
// replays them, optionally transposed, on the store-row stream.
// Ports:
//   clk, rstnn                  clock, asynchronous active-low reset
//   clear                       synchronous abort back to IDLE
//   transpose                   replay mode, latched on the first row of a tile
//   load_tensor_row_w*          load-row handshake (valid/last/data in, ready out)
//   store_tensor_row_r*         store-row handshake (valid/last/data out, ready in)
//   num_rows                    rows captured in the current tile
//   busy                        block is not IDLE
//   overflow                    sticky: capacity reached without wlast
module dca_matrix_row_buffer #(
    parameter int unsigned BW_TENSOR_SCALAR = 33,
    parameter int unsigned MATRIX_NUM_COL   = 4,
    parameter int unsigned MATRIX_NUM_ROW   = 4,
    localparam int unsigned RW       = BW_TENSOR_SCALAR * MATRIX_NUM_COL,
    localparam int unsigned BW_COUNT = $clog2(MATRIX_NUM_ROW + 1)
) (
    input  logic                clk,
    input  logic                rstnn,
    input  logic                clear,
    input  logic                transpose,
    input  logic                load_tensor_row_wvalid,
    input  logic                load_tensor_row_wlast,
    input  logic [RW-1:0]       load_tensor_row_wdata,
    output logic                load_tensor_row_wready,
    output logic                store_tensor_row_rvalid,
    output logic                store_tensor_row_rlast,
    input  logic                store_tensor_row_rready,
    output logic [RW-1:0]       store_tensor_row_rdata,
    output logic [BW_COUNT-1:0] num_rows,
    output logic                busy,
    output logic                overflow
);

    localparam int unsigned MAX_DIM   = (MATRIX_NUM_COL > MATRIX_NUM_ROW) ? MATRIX_NUM_COL : MATRIX_NUM_ROW;
    localparam int unsigned RPTR_W    = $clog2(MAX_DIM + 1);
    localparam int unsigned ROW_IDX_W = (MATRIX_NUM_ROW > 1) ? $clog2(MATRIX_NUM_ROW) : 1;
    localparam int unsigned COL_IDX_W = (MATRIX_NUM_COL > 1) ? $clog2(MATRIX_NUM_COL) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_FULL,
        S_DRAIN
    } state_t;

    state_t                      state_q, state_d;
    logic [BW_COUNT-1:0]         num_rows_q;   // also serves as the write pointer
    logic [RPTR_W-1:0]           rptr_q;
    logic                        tr_q;
    logic                        overflow_q;
    logic [BW_TENSOR_SCALAR-1:0] mem [MATRIX_NUM_ROW][MATRIX_NUM_COL];

    logic                load_fire;
    logic                store_fire;
    logic [BW_COUNT-1:0] rows_next;
    logic                cap_hit;
    logic [RPTR_W-1:0]   replay_len;
    logic [ROW_IDX_W-1:0] wr_idx;
    logic [ROW_IDX_W-1:0] rd_row;
    logic [COL_IDX_W-1:0] rd_col;

    // Handshake decode straight from the state register
    assign load_tensor_row_wready  = (state_q == S_IDLE) || (state_q == S_FILL);
    assign store_tensor_row_rvalid = (state_q == S_DRAIN);
    assign busy                    = (state_q != S_IDLE);
    assign num_rows                = num_rows_q;
    assign overflow                = overflow_q;

    assign load_fire  = load_tensor_row_wvalid && load_tensor_row_wready;
    assign store_fire = store_tensor_row_rvalid && store_tensor_row_rready;
    assign rows_next  = num_rows_q + BW_COUNT'(1);
    assign cap_hit    = (rows_next == BW_COUNT'(MATRIX_NUM_ROW));

    // Transposed replay always emits one row per column
    assign replay_len = tr_q ? RPTR_W'(MATRIX_NUM_COL) : RPTR_W'(num_rows_q);
    assign store_tensor_row_rlast = store_tensor_row_rvalid && (rptr_q == replay_len - RPTR_W'(1));

    assign wr_idx = num_rows_q[ROW_IDX_W-1:0];
    assign rd_row = rptr_q[ROW_IDX_W-1:0];
    assign rd_col = rptr_q[COL_IDX_W-1:0];

    // State register
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_FILL: begin
                    if (load_fire) begin
                        if (load_tensor_row_wlast || cap_hit) state_d = S_FULL;
                        else                                  state_d = S_FILL;
                    end
                end
                S_FULL:  state_d = S_DRAIN;
                S_DRAIN: if (store_fire && store_tensor_row_rlast) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Counters, transpose latch and sticky overflow
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            num_rows_q <= '0;
            rptr_q     <= '0;
            tr_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            num_rows_q <= '0;
            rptr_q     <= '0;
            tr_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_FILL: begin
                    if (load_fire) begin
                        num_rows_q <= rows_next;
                        if (state_q == S_IDLE) tr_q <= transpose;
                        if (cap_hit && !load_tensor_row_wlast) overflow_q <= 1'b1;
                    end
                end
                S_FULL: rptr_q <= '0;
                S_DRAIN: begin
                    if (store_fire) begin
                        rptr_q <= rptr_q + RPTR_W'(1);
                        if (store_tensor_row_rlast) begin
                            num_rows_q <= '0;
                            rptr_q     <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Row storage; deliberately not reset or cleared between tiles
    always_ff @(posedge clk) begin
        if (load_fire && !clear) begin
            for (int c = 0; c < int'(MATRIX_NUM_COL); c++) begin
                mem[wr_idx][c] <= load_tensor_row_wdata[c*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR];
            end
        end
    end

    // Replay data: row-major or column-major, zero outside DRAIN
    always_comb begin
        store_tensor_row_rdata = '0;
        if (state_q == S_DRAIN) begin
            for (int c = 0; c < int'(MATRIX_NUM_COL); c++) begin
                if (!tr_q) begin
                    store_tensor_row_rdata[c*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR] = mem[rd_row][c];
                end else if ((c < int'(MATRIX_NUM_ROW)) && (BW_COUNT'(c) < num_rows_q)) begin
                    // uncaptured rows may hold a previous tile, so mask them
                    store_tensor_row_rdata[c*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR] = mem[c][rd_col];
                end
            end
        end
    end

endmodule

// File: tb/tb_dca_matrix_row_buffer.sv
// Directed testbench for dca_matrix_row_buffer (default parameters).
module tb_dca_matrix_row_buffer;

    localparam int unsigned BW  = 33;
    localparam int unsigned COL = 4;
    localparam int unsigned ROW = 4;
    localparam int unsigned RW  = BW * COL;
    localparam int unsigned BWC = $clog2(ROW + 1);

    logic           clk = 1'b0;
    logic           rstnn;
    logic           clear;
    logic           transpose;
    logic           wvalid;
    logic           wlast;
    logic [RW-1:0]  wdata;
    logic           wready;
    logic           rvalid;
    logic           rlast;
    logic           rready;
    logic [RW-1:0]  rdata;
    logic [BWC-1:0] num_rows;
    logic           busy;
    logic           overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    dca_matrix_row_buffer #(
        .BW_TENSOR_SCALAR(BW),
        .MATRIX_NUM_COL  (COL),
        .MATRIX_NUM_ROW  (ROW)
    ) dut (
        .clk                    (clk),
        .rstnn                  (rstnn),
        .clear                  (clear),
        .transpose              (transpose),
        .load_tensor_row_wvalid (wvalid),
        .load_tensor_row_wlast  (wlast),
        .load_tensor_row_wdata  (wdata),
        .load_tensor_row_wready (wready),
        .store_tensor_row_rvalid(rvalid),
        .store_tensor_row_rlast (rlast),
        .store_tensor_row_rready(rready),
        .store_tensor_row_rdata (rdata),
        .num_rows               (num_rows),
        .busy                   (busy),
        .overflow               (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] mk_row(input logic [BW-1:0] s0, input logic [BW-1:0] s1,
                                             input logic [BW-1:0] s2, input logic [BW-1:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstnn = 1'b0;
        #3;
        n_cmp++; if (wready !== 1'b1) begin n_fail++; $display("FAIL reset_wready got %0b want 1", wready); end
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %0b want 0", rvalid); end
        n_cmp++; if (rlast !== 1'b0) begin n_fail++; $display("FAIL reset_rlast got %0b want 0", rlast); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (num_rows !== 3'd0) begin n_fail++; $display("FAIL reset_num_rows got %0d want 0", num_rows); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        n_cmp++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
        tick();
        tick();
        rstnn = 1'b1;
        tick();
    endtask

    task automatic test_passthrough();
        logic [RW-1:0] rows [4];
        rows[0] = mk_row(33'h1_0000_0001, 33'h0_0000_0002, 33'h0_0000_0003, 33'h1_FFFF_FFFF);
        rows[1] = mk_row(33'h0_0000_0011, 33'h1_2345_6789, 33'h0_0000_0013, 33'h0_0000_0014);
        rows[2] = mk_row(33'h0_0000_0021, 33'h0_0000_0022, 33'h1_0BAD_CAFE, 33'h0_0000_0024);
        rows[3] = mk_row(33'h0_DEAD_BEEF, 33'h0_0000_0032, 33'h0_0000_0033, 33'h1_0000_0034);
        transpose = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wvalid = 1'b1; wdata = rows[i]; wlast = (i == 3);
            n_cmp++; if (wready !== 1'b1) begin n_fail++; $display("FAIL pt_wready row %0d got %0b want 1", i, wready); end
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        n_cmp++; if (wready !== 1'b0) begin n_fail++; $display("FAIL pt_full_wready got %0b want 0", wready); end
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL pt_full_rvalid got %0b want 0", rvalid); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pt_full_busy got %0b want 1", busy); end
        tick();
        rready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL pt_rvalid row %0d got %0b want 1", j, rvalid); end
            n_cmp++; if (rdata !== rows[j]) begin n_fail++; $display("FAIL pt_rdata row %0d got %h want %h", j, rdata, rows[j]); end
            n_cmp++; if (rlast !== (j == 3)) begin n_fail++; $display("FAIL pt_rlast row %0d got %0b want %0b", j, rlast, j == 3); end
            n_cmp++; if (num_rows !== 3'd4) begin n_fail++; $display("FAIL pt_num_rows row %0d got %0d want 4", j, num_rows); end
            tick();
        end
        rready = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pt_end_busy got %0b want 0", busy); end
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL pt_end_rvalid got %0b want 0", rvalid); end
        n_cmp++; if (wready !== 1'b1) begin n_fail++; $display("FAIL pt_end_wready got %0b want 1", wready); end
        n_cmp++; if (num_rows !== 3'd0) begin n_fail++; $display("FAIL pt_end_num_rows got %0d want 0", num_rows); end
    endtask

    task automatic test_transpose();
        logic [RW-1:0] exp;
        for (int r = 0; r < 4; r++) begin
            wvalid = 1'b1; wlast = (r == 3);
            wdata = mk_row(BW'(10*r), BW'(10*r+1), BW'(10*r+2), BW'(10*r+3));
            transpose = (r == 0);   // only the first row's value should matter
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0; transpose = 1'b0;
        tick();
        tick();
        rready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            exp = mk_row(BW'(j), BW'(10+j), BW'(20+j), BW'(30+j));
            n_cmp++; if (rdata !== exp) begin n_fail++; $display("FAIL tr_rdata row %0d got %h want %h", j, rdata, exp); end
            n_cmp++; if (rlast !== (j == 3)) begin n_fail++; $display("FAIL tr_rlast row %0d got %0b want %0b", j, rlast, j == 3); end
            tick();
        end
        rready = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tr_end_busy got %0b want 0", busy); end
    endtask

    task automatic test_partial_transpose();
        logic [RW-1:0] exp;
        transpose = 1'b1;
        wvalid = 1'b1; wlast = 1'b0; wdata = mk_row(100, 101, 102, 103);
        tick();
        transpose = 1'b0;
        wlast = 1'b1; wdata = mk_row(200, 201, 202, 203);
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        tick();
        tick();
        rready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            exp = mk_row(BW'(100+j), BW'(200+j), '0, '0);
            n_cmp++; if (rdata !== exp) begin n_fail++; $display("FAIL ptr_rdata row %0d got %h want %h", j, rdata, exp); end
            n_cmp++; if (rlast !== (j == 3)) begin n_fail++; $display("FAIL ptr_rlast row %0d got %0b want %0b", j, rlast, j == 3); end
            n_cmp++; if (num_rows !== 3'd2) begin n_fail++; $display("FAIL ptr_num_rows row %0d got %0d want 2", j, num_rows); end
            tick();
        end
        rready = 1'b0;
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL ptr_end_rvalid got %0b want 0", rvalid); end
    endtask

    task automatic test_single_row();
        logic [RW-1:0] s;
        s = mk_row(33'h1_5555_AAAA, 7, 8, 9);
        transpose = 1'b0;
        wvalid = 1'b1; wlast = 1'b1; wdata = s;
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        n_cmp++; if (wready !== 1'b0) begin n_fail++; $display("FAIL single_full_wready got %0b want 0", wready); end
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL single_full_rvalid got %0b want 0", rvalid); end
        n_cmp++; if (num_rows !== 3'd1) begin n_fail++; $display("FAIL single_num_rows got %0d want 1", num_rows); end
        tick();
        n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL single_rvalid got %0b want 1", rvalid); end
        n_cmp++; if (rlast !== 1'b1) begin n_fail++; $display("FAIL single_rlast got %0b want 1", rlast); end
        n_cmp++; if (rdata !== s) begin n_fail++; $display("FAIL single_rdata got %h want %h", rdata, s); end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_end_busy got %0b want 0", busy); end
    endtask

    task automatic test_overflow();
        logic [RW-1:0] rows [4];
        for (int r = 0; r < 4; r++) rows[r] = mk_row(BW'(500+r), BW'(600+r), BW'(700+r), BW'(800+r));
        transpose = 1'b0;
        wlast = 1'b0;
        for (int r = 0; r < 4; r++) begin
            wvalid = 1'b1; wdata = rows[r];
            tick();
        end
        // producer keeps a fifth row pending; it must stall, not be dropped
        wdata = mk_row(900, 901, 902, 903);
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", overflow); end
        n_cmp++; if (wready !== 1'b0) begin n_fail++; $display("FAIL ovf_full_wready got %0b want 0", wready); end
        n_cmp++; if (num_rows !== 3'd4) begin n_fail++; $display("FAIL ovf_num_rows got %0d want 4", num_rows); end
        tick();
        rready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            n_cmp++; if (wready !== 1'b0) begin n_fail++; $display("FAIL ovf_drain_wready row %0d got %0b want 0", j, wready); end
            n_cmp++; if (rdata !== rows[j]) begin n_fail++; $display("FAIL ovf_rdata row %0d got %h want %h", j, rdata, rows[j]); end
            n_cmp++; if (rlast !== (j == 3)) begin n_fail++; $display("FAIL ovf_rlast row %0d got %0b want %0b", j, rlast, j == 3); end
            tick();
        end
        rready = 1'b0;
        n_cmp++; if (wready !== 1'b1) begin n_fail++; $display("FAIL ovf_idle_wready got %0b want 1", wready); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
        tick();
        wvalid = 1'b0;
        n_cmp++; if (num_rows !== 3'd1) begin n_fail++; $display("FAIL ovf_new_tile_rows got %0d want 1", num_rows); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovf_new_tile_busy got %0b want 1", busy); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_flag got %0b want 0", overflow); end
        n_cmp++; if (num_rows !== 3'd0) begin n_fail++; $display("FAIL ovf_clear_rows got %0d want 0", num_rows); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_busy got %0b want 0", busy); end
    endtask

    task automatic test_backpressure_clear();
        logic [RW-1:0] rows [4];
        for (int r = 0; r < 4; r++) rows[r] = mk_row(BW'(40+r), BW'(50+r), 33'h1_0000_0000 | BW'(r), BW'(60+r));
        transpose = 1'b0;
        for (int r = 0; r < 4; r++) begin
            wvalid = 1'b1; wdata = rows[r]; wlast = (r == 3);
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        tick();
        rready = 1'b0;
        n_cmp++; if (rdata !== rows[0]) begin n_fail++; $display("FAIL bp_stall0a got %h want %h", rdata, rows[0]); end
        tick();
        n_cmp++; if (rdata !== rows[0]) begin n_fail++; $display("FAIL bp_stall0b got %h want %h", rdata, rows[0]); end
        n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL bp_stall_rvalid got %0b want 1", rvalid); end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        n_cmp++; if (rdata !== rows[1]) begin n_fail++; $display("FAIL bp_row1a got %h want %h", rdata, rows[1]); end
        n_cmp++; if (rlast !== 1'b0) begin n_fail++; $display("FAIL bp_row1_rlast got %0b want 0", rlast); end
        tick();
        n_cmp++; if (rdata !== rows[1]) begin n_fail++; $display("FAIL bp_row1b got %h want %h", rdata, rows[1]); end
        clear = 1'b1; rready = 1'b1;
        tick();
        clear = 1'b0; rready = 1'b0;
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL clr_rvalid got %0b want 0", rvalid); end
        n_cmp++; if (wready !== 1'b1) begin n_fail++; $display("FAIL clr_wready got %0b want 1", wready); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow got %0b want 0", overflow); end
        n_cmp++; if (num_rows !== 3'd0) begin n_fail++; $display("FAIL clr_num_rows got %0d want 0", num_rows); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy got %0b want 0", busy); end
    endtask

    task automatic test_reset_mid_fill();
        transpose = 1'b0;
        wvalid = 1'b1; wlast = 1'b0;
        wdata = mk_row(1, 2, 3, 4);
        tick();
        wdata = mk_row(5, 6, 7, 8);
        tick();
        wvalid = 1'b0;
        n_cmp++; if (num_rows !== 3'd2) begin n_fail++; $display("FAIL rst_pre_rows got %0d want 2", num_rows); end
        rstnn = 1'b0;
        #1;
        n_cmp++; if (num_rows !== 3'd0) begin n_fail++; $display("FAIL rst_async_rows got %0d want 0", num_rows); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got %0b want 0", busy); end
        n_cmp++; if (wready !== 1'b1) begin n_fail++; $display("FAIL rst_async_wready got %0b want 1", wready); end
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_async_rvalid got %0b want 0", rvalid); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_async_overflow got %0b want 0", overflow); end
        tick();
        rstnn = 1'b1;
        tick();
    endtask

    initial begin
        clear = 1'b0; transpose = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        wdata = '0; rready = 1'b0;
        test_reset();
        test_passthrough();
        test_transpose();
        test_partial_transpose();
        test_single_row();
        test_overflow();
        test_backpressure_clear();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
